// File: rtl/pm_access_controller.sv
// Access sequencer for the single-port program memory: loader writes during BOOT,
// fetch reads (with bounded loader starvation) during RUN, fixed-latency read return.
module pm_access_controller #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic              boot_done,
  output logic [ADDR_W:0]   load_count,
  output logic [ADDR_W-1:0] pm_address,
  output logic              pm_rd,
  output logic              pm_wr,
  output logic [DATA_W-1:0] pm_wdata,
  input  logic [DATA_W-1:0] pm_inst
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          starve_hit;
  logic          ld_acc;
  logic          rd_pipe_q;

  // Handshakes: a loader beat transfers in a cycle where ld_valid && ld_ready;
  // a fetch transfers in a cycle where fetch_gnt (which implies fetch_req).
  // Both responses are combinational and at most one of them is granted per cycle.
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign ld_acc     = ld_valid & ld_ready;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        fetch_gnt = fetch_req & ~starve_hit;
        ld_ready  = ld_valid & (~fetch_req | starve_hit);
        // Count only fetch grants that overtook a waiting loader beat.
        if (!ld_valid || ld_ready) starve_d = '0;
        else if (fetch_gnt)        starve_d = starve_q + 1'b1;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      starve_q   <= '0;
      boot_done  <= 1'b0;
      load_count <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      boot_done <= (state_d == ST_RUN);
      if (ld_acc && (load_count != '1)) load_count <= load_count + 1'b1;
    end
  end

  // Memory-side strobes are registered; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_rd      <= 1'b0;
      pm_wr      <= 1'b0;
      pm_address <= '0;
      pm_wdata   <= '0;
    end else begin
      pm_rd <= fetch_gnt;
      pm_wr <= ld_acc;
      if (fetch_gnt) begin
        pm_address <= fetch_addr;
      end else if (ld_acc) begin
        pm_address <= ld_addr;
        pm_wdata   <= ld_data;
      end
    end
  end

  // Read return: strobe at E0, memory registers at E1, capture at E2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_q  <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
    end else begin
      rd_pipe_q  <= pm_rd;
      inst_valid <= rd_pipe_q;
      if (rd_pipe_q) inst_out <= pm_inst;
    end
  end

endmodule
